// File: rtl/frame_serializer.sv
// Parallel-to-serial frame shifter: loads a DATA_W frame, then emits it as
// OUT_W-bit beats under a valid/ready handshake, with abort and finish pulse.
module frame_serializer #(
  parameter int DATA_W    = 640,
  parameter int OUT_W     = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                                 iCLK,
  input  logic                                 iRST_n,
  input  logic [DATA_W-1:0]                    iDATA,
  input  logic                                 iVALID,
  output logic                                 oREADY,
  output logic [OUT_W-1:0]                     oPIXEL,
  output logic                                 oPIXEL_VALID,
  input  logic                                 iOUT_READY,
  input  logic                                 iABORT,
  output logic                                 oBUSY,
  output logic                                 oFINISHED,
  output logic [$clog2(DATA_W/OUT_W+1)-1:0]    oBEAT_CNT
);

  localparam int BEATS = DATA_W / OUT_W;
  localparam int CNT_W = $clog2(BEATS + 1);

  // Beat handshake: a beat transfers on any rising edge where oPIXEL_VALID
  // and iOUT_READY are both high; oPIXEL is stable while iOUT_READY is low.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                finished_q, finished_d;

  logic [DATA_W-1:0]   shifted;
  logic [OUT_W-1:0]    pixel_slice;
  logic                handshake;
  logic                last_beat;

  // The emitting end always sits at a fixed slice, so oPIXEL is a flop output.
  generate
    if (DATA_W == OUT_W) begin : g_single
      assign shifted = '0;
    end else if (MSB_FIRST != 0) begin : g_msb_shift
      assign shifted = {data_q[DATA_W-OUT_W-1:0], {OUT_W{1'b0}}};
    end else begin : g_lsb_shift
      assign shifted = {{OUT_W{1'b0}}, data_q[DATA_W-1:OUT_W]};
    end

    if (MSB_FIRST != 0) begin : g_msb_pix
      assign pixel_slice = data_q[DATA_W-1 -: OUT_W];
    end else begin : g_lsb_pix
      assign pixel_slice = data_q[OUT_W-1:0];
    end
  endgenerate

  assign handshake = (state_q == RUN) && iOUT_READY;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      cnt_q      <= '0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      finished_q <= finished_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    finished_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Abort has no meaning here, so a frame still loads alongside it.
        if (iVALID) begin
          data_d  = iDATA;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort wins over a final handshake so no finish pulse is produced.
        if (iABORT) begin
          state_d = IDLE;
          data_d  = '0;
          cnt_d   = '0;
        end else if (handshake) begin
          data_d = shifted;
          if (last_beat) begin
            state_d    = IDLE;
            cnt_d      = '0;
            finished_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        data_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    oREADY       = 1'b0;
    oBUSY        = 1'b0;
    oPIXEL_VALID = 1'b0;
    oPIXEL       = pixel_slice;
    oFINISHED    = finished_q;
    oBEAT_CNT    = cnt_q;
    if (state_q == RUN) begin
      oBUSY        = 1'b1;
      oPIXEL_VALID = 1'b1;
    end else begin
      oREADY = 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: MSB-first 1-bit, LSB-first 2-bit and
// single-beat configurations, with stall, abort, reset and back-to-back cases.
module tb_frame_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Instance A: DATA_W=8, OUT_W=1, MSB first
  logic [7:0] a_data = '0;
  logic       a_valid = 0, a_ordy = 1, a_abort = 0;
  logic       a_ready, a_pix, a_pv, a_busy, a_fin;
  logic [3:0] a_cnt;

  // Instance B: DATA_W=8, OUT_W=2, LSB first
  logic [7:0] b_data = '0;
  logic       b_valid = 0, b_ordy = 1, b_abort = 0;
  logic       b_ready, b_pv, b_busy, b_fin;
  logic [1:0] b_pix;
  logic [2:0] b_cnt;

  // Instance C: DATA_W=OUT_W=4, single-beat frames
  logic [3:0] c_data = '0;
  logic       c_valid = 0, c_ordy = 1, c_abort = 0;
  logic       c_ready, c_pv, c_busy, c_fin;
  logic [3:0] c_pix;
  logic [0:0] c_cnt;

  frame_serializer #(.DATA_W(8), .OUT_W(1), .MSB_FIRST(1)) dut_a (
    .iCLK(clk), .iRST_n(rst_n), .iDATA(a_data), .iVALID(a_valid), .oREADY(a_ready),
    .oPIXEL(a_pix), .oPIXEL_VALID(a_pv), .iOUT_READY(a_ordy), .iABORT(a_abort),
    .oBUSY(a_busy), .oFINISHED(a_fin), .oBEAT_CNT(a_cnt));

  frame_serializer #(.DATA_W(8), .OUT_W(2), .MSB_FIRST(0)) dut_b (
    .iCLK(clk), .iRST_n(rst_n), .iDATA(b_data), .iVALID(b_valid), .oREADY(b_ready),
    .oPIXEL(b_pix), .oPIXEL_VALID(b_pv), .iOUT_READY(b_ordy), .iABORT(b_abort),
    .oBUSY(b_busy), .oFINISHED(b_fin), .oBEAT_CNT(b_cnt));

  frame_serializer #(.DATA_W(4), .OUT_W(4), .MSB_FIRST(1)) dut_c (
    .iCLK(clk), .iRST_n(rst_n), .iDATA(c_data), .iVALID(c_valid), .oREADY(c_ready),
    .oPIXEL(c_pix), .oPIXEL_VALID(c_pv), .iOUT_READY(c_ordy), .iABORT(c_abort),
    .oBUSY(c_busy), .oFINISHED(c_fin), .oBEAT_CNT(c_cnt));

  // Hand-derived beat sequences
  logic       bits_a5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic       bits_96 [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic       bits_3c [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       bits_01 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [1:0] beats_b4 [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0d want=1", a_ready); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d want=0", a_busy); end
    total++; if (a_pv !== 1'b0) begin bad++; $display("FAIL reset_pv got=%0d want=0", a_pv); end
    total++; if (a_pix !== 1'b0) begin bad++; $display("FAIL reset_pix got=%0d want=0", a_pix); end
    total++; if (a_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", a_cnt); end
    total++; if (a_fin !== 1'b0) begin bad++; $display("FAIL reset_fin got=%0d want=0", a_fin); end
    total++; if (b_ready !== 1'b1 || c_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_bc got=%0d%0d want=11", b_ready, c_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_a5();
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL a5_idle_ready got=%0d want=1", a_ready); end
    a_data = 8'hA5; a_valid = 1'b1; a_ordy = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++; if (a_pix !== bits_a5[i] || a_pv !== 1'b1) begin bad++; $display("FAIL a5_beat%0d pix/pv got=%0d/%0d want=%0d/1", i, a_pix, a_pv, bits_a5[i]); end
      total++; if (a_cnt !== 4'(i) || a_fin !== 1'b0 || a_busy !== 1'b1) begin bad++; $display("FAIL a5_cnt%0d cnt/fin/busy got=%0d/%0d/%0d want=%0d/0/1", i, a_cnt, a_fin, a_busy, i); end
      @(negedge clk);
    end
    total++; if (a_fin !== 1'b1 || a_ready !== 1'b1 || a_busy !== 1'b0 || a_cnt !== 4'd0) begin bad++; $display("FAIL a5_finish fin/ready/busy/cnt got=%0d/%0d/%0d/%0d want=1/1/0/0", a_fin, a_ready, a_busy, a_cnt); end
    @(negedge clk);
    total++; if (a_fin !== 1'b0) begin bad++; $display("FAIL a5_fin_pulse got=%0d want=0", a_fin); end
  endtask

  task automatic test_lsb_2bit();
    b_data = 8'hB4; b_valid = 1'b1; b_ordy = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (b_pix !== beats_b4[i] || b_pv !== 1'b1 || b_cnt !== 3'(i)) begin bad++; $display("FAIL b4_beat%0d pix/pv/cnt got=%0d/%0d/%0d want=%0d/1/%0d", i, b_pix, b_pv, b_cnt, beats_b4[i], i); end
      @(negedge clk);
    end
    total++; if (b_fin !== 1'b1 || b_ready !== 1'b1) begin bad++; $display("FAIL b4_finish fin/ready got=%0d/%0d want=1/1", b_fin, b_ready); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int idx;
    a_data = 8'hA5; a_valid = 1'b1; a_ordy = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      idx = (cyc < 2) ? cyc : (cyc <= 5) ? 2 : cyc - 3;
      a_ordy = !(cyc >= 2 && cyc < 5);
      total++; if (a_pix !== bits_a5[idx] || a_cnt !== 4'(idx) || a_fin !== 1'b0) begin bad++; $display("FAIL stall_cyc%0d pix/cnt/fin got=%0d/%0d/%0d want=%0d/%0d/0", cyc, a_pix, a_cnt, a_fin, bits_a5[idx], idx); end
      @(negedge clk);
    end
    a_ordy = 1'b1;
    total++; if (a_fin !== 1'b1) begin bad++; $display("FAIL stall_finish_at_11 got=%0d want=1", a_fin); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    a_data = 8'hA5; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    total++; if (a_cnt !== 4'd4) begin bad++; $display("FAIL abort_pre_cnt got=%0d want=4", a_cnt); end
    a_abort = 1'b1; a_valid = 1'b1; a_data = 8'hFF;
    @(negedge clk);
    a_abort = 1'b0; a_valid = 1'b0;
    total++; if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_fin !== 1'b0 || a_cnt !== 4'd0) begin bad++; $display("FAIL abort_idle ready/busy/fin/cnt got=%0d/%0d/%0d/%0d want=1/0/0/0", a_ready, a_busy, a_fin, a_cnt); end
    total++; if (a_pix !== 1'b0 || a_pv !== 1'b0) begin bad++; $display("FAIL abort_cleared pix/pv got=%0d/%0d want=0/0", a_pix, a_pv); end
    @(negedge clk);
    total++; if (a_busy !== 1'b0 || a_fin !== 1'b0) begin bad++; $display("FAIL abort_ff_rejected busy/fin got=%0d/%0d want=0/0", a_busy, a_fin); end
    a_data = 8'h96; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++; if (a_pix !== bits_96[i] || a_cnt !== 4'(i)) begin bad++; $display("FAIL abort_reload_beat%0d pix/cnt got=%0d/%0d want=%0d/%0d", i, a_pix, a_cnt, bits_96[i], i); end
      @(negedge clk);
    end
    total++; if (a_fin !== 1'b1) begin bad++; $display("FAIL abort_reload_finish got=%0d want=1", a_fin); end
    @(negedge clk);
  endtask

  task automatic test_abort_edges();
    a_abort = 1'b1; a_valid = 1'b1; a_data = 8'h80;
    @(negedge clk);
    a_abort = 1'b0; a_valid = 1'b0;
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL idle_abort_load busy got=%0d want=1", a_busy); end
    for (int i = 0; i < 8; i++) begin
      total++; if (a_pix !== (i == 0) || a_cnt !== 4'(i)) begin bad++; $display("FAIL abort_last_beat%0d pix/cnt got=%0d/%0d want=%0d/%0d", i, a_pix, a_cnt, (i == 0), i); end
      if (i == 7) a_abort = 1'b1;
      @(negedge clk);
    end
    a_abort = 1'b0;
    total++; if (a_fin !== 1'b0 || a_ready !== 1'b1 || a_cnt !== 4'd0) begin bad++; $display("FAIL abort_last fin/ready/cnt got=%0d/%0d/%0d want=0/1/0", a_fin, a_ready, a_cnt); end
    @(negedge clk);
    total++; if (a_fin !== 1'b0) begin bad++; $display("FAIL abort_last_late_fin got=%0d want=0", a_fin); end
  endtask

  task automatic test_reset_mid();
    a_data = 8'hA5; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    total++; if (a_cnt !== 4'd5) begin bad++; $display("FAIL rst_mid_pre_cnt got=%0d want=5", a_cnt); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_pv !== 1'b0) begin bad++; $display("FAIL rst_mid_async ready/busy/pv got=%0d/%0d/%0d want=1/0/0", a_ready, a_busy, a_pv); end
    total++; if (a_pix !== 1'b0 || a_cnt !== 4'd0 || a_fin !== 1'b0) begin bad++; $display("FAIL rst_mid_async pix/cnt/fin got=%0d/%0d/%0d want=0/0/0", a_pix, a_cnt, a_fin); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (a_fin !== 1'b0 || a_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_release fin/ready got=%0d/%0d want=0/1", a_fin, a_ready); end
    a_data = 8'h3C; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++; if (a_pix !== bits_3c[i] || a_cnt !== 4'(i)) begin bad++; $display("FAIL rst_3c_beat%0d pix/cnt got=%0d/%0d want=%0d/%0d", i, a_pix, a_cnt, bits_3c[i], i); end
      @(negedge clk);
    end
    total++; if (a_fin !== 1'b1) begin bad++; $display("FAIL rst_3c_finish got=%0d want=1", a_fin); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    a_data = 8'h01; a_valid = 1'b1;
    @(negedge clk);
    a_data = 8'h80;
    for (int i = 0; i < 8; i++) begin
      total++; if (a_pix !== bits_01[i] || a_cnt !== 4'(i)) begin bad++; $display("FAIL b2b_01_beat%0d pix/cnt got=%0d/%0d want=%0d/%0d", i, a_pix, a_cnt, bits_01[i], i); end
      @(negedge clk);
    end
    total++; if (a_fin !== 1'b1 || a_ready !== 1'b1) begin bad++; $display("FAIL b2b_finish fin/ready got=%0d/%0d want=1/1", a_fin, a_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    total++; if (a_busy !== 1'b1 || a_pix !== 1'b1 || a_cnt !== 4'd0 || a_fin !== 1'b0) begin bad++; $display("FAIL b2b_80_first busy/pix/cnt/fin got=%0d/%0d/%0d/%0d want=1/1/0/0", a_busy, a_pix, a_cnt, a_fin); end
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      total++; if (a_pix !== 1'b0 || a_cnt !== 4'(i)) begin bad++; $display("FAIL b2b_80_beat%0d pix/cnt got=%0d/%0d want=0/%0d", i, a_pix, a_cnt, i); end
    end
    @(negedge clk);
    total++; if (a_fin !== 1'b1) begin bad++; $display("FAIL b2b_80_finish got=%0d want=1", a_fin); end
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    c_data = 4'h9; c_valid = 1'b1; c_ordy = 1'b1;
    @(negedge clk);
    c_valid = 1'b0;
    total++; if (c_pix !== 4'h9 || c_pv !== 1'b1 || c_cnt !== 1'b0 || c_busy !== 1'b1) begin bad++; $display("FAIL single_beat pix/pv/cnt/busy got=%0h/%0d/%0d/%0d want=9/1/0/1", c_pix, c_pv, c_cnt, c_busy); end
    @(negedge clk);
    total++; if (c_fin !== 1'b1 || c_ready !== 1'b1 || c_pix !== 4'h0) begin bad++; $display("FAIL single_finish fin/ready/pix got=%0d/%0d/%0h want=1/1/0", c_fin, c_ready, c_pix); end
    @(negedge clk);
    total++; if (c_fin !== 1'b0) begin bad++; $display("FAIL single_fin_pulse got=%0d want=0", c_fin); end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_lsb_2bit();
    test_stall();
    test_abort();
    test_abort_edges();
    test_reset_mid();
    test_back_to_back();
    test_single_beat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
